// File: rtl/bist_scan_sequencer.sv
// Scan-BIST session sequencer: drives LFSR/MISR/scan-enable/test-mux controls through
// INIT, SHIFT, CAPTURE, UNLOAD and COMPARE, then reports the signature check result.
module bist_scan_sequencer #(
  parameter int unsigned       CHAIN_LEN    = 8,
  parameter int unsigned       NUM_PATTERNS = 16,
  parameter int unsigned       PAT_W        = 8,
  parameter int unsigned       SIG_W        = 8,
  parameter logic [SIG_W-1:0]  GOLDEN_SIG   = SIG_W'(8'hA5)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             ABORT,
  input  logic [SIG_W-1:0] SIG,
  output logic             TEST_MODE,
  output logic             SCAN_EN,
  output logic             LFSR_LOAD,
  output logic             LFSR_EN,
  output logic             MISR_CLR,
  output logic             MISR_EN,
  output logic             BUSY,
  output logic             BIST_END,
  output logic             PASS_FAIL,
  output logic [PAT_W-1:0] PATTERN_CNT
);

  localparam int unsigned      CNT_W      = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
  localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(CHAIN_LEN - 1);
  localparam logic [PAT_W-1:0] PAT_LAST   = PAT_W'(NUM_PATTERNS - 1);

  typedef enum logic [2:0] {
    StIdle, StInit, StShift, StCapture, StUnload, StCompare, StDone
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   shift_cnt_q, shift_cnt_d;
  logic [PAT_W-1:0]   pattern_cnt_q, pattern_cnt_d;
  logic               pass_fail_q, pass_fail_d;
  logic               test_mode_q, test_mode_d;
  logic               scan_en_q, scan_en_d;
  logic               lfsr_load_q, lfsr_load_d;
  logic               lfsr_en_q, lfsr_en_d;
  logic               misr_clr_q, misr_clr_d;
  logic               misr_en_q, misr_en_d;
  logic               busy_q, busy_d;
  logic               bist_end_q, bist_end_d;
  logic               in_session;

  assign in_session = state_q inside {StInit, StShift, StCapture, StUnload, StCompare};

  always_comb begin
    state_d       = state_q;
    shift_cnt_d   = shift_cnt_q;
    pattern_cnt_d = pattern_cnt_q;
    pass_fail_d   = pass_fail_q;

    unique case (state_q)
      StIdle: begin
        // Clear on entry so INIT already shows a fresh count and no stale result.
        if (START) begin
          state_d       = StInit;
          shift_cnt_d   = '0;
          pattern_cnt_d = '0;
          pass_fail_d   = 1'b0;
        end
      end
      StInit: begin
        state_d     = StShift;
        shift_cnt_d = '0;
      end
      StShift: begin
        if (shift_cnt_q == SHIFT_LAST) begin
          state_d     = StCapture;
          shift_cnt_d = '0;
        end else begin
          shift_cnt_d = shift_cnt_q + 1'b1;
        end
      end
      StCapture: begin
        pattern_cnt_d = pattern_cnt_q + 1'b1;
        state_d       = (pattern_cnt_q == PAT_LAST) ? StUnload : StShift;
      end
      StUnload: begin
        if (shift_cnt_q == SHIFT_LAST) begin
          state_d     = StCompare;
          shift_cnt_d = '0;
        end else begin
          shift_cnt_d = shift_cnt_q + 1'b1;
        end
      end
      StCompare: begin
        pass_fail_d = (SIG == GOLDEN_SIG);
        state_d     = StDone;
      end
      StDone: begin
        if (!START) begin
          state_d       = StIdle;
          pattern_cnt_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase

    if (ABORT && in_session) begin
      state_d       = StIdle;
      shift_cnt_d   = '0;
      pattern_cnt_d = '0;
      pass_fail_d   = 1'b0;
    end
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    test_mode_d = 1'b0;
    scan_en_d   = 1'b0;
    lfsr_load_d = 1'b0;
    lfsr_en_d   = 1'b0;
    misr_clr_d  = 1'b0;
    misr_en_d   = 1'b0;
    busy_d      = 1'b0;
    bist_end_d  = 1'b0;

    unique case (state_d)
      StIdle: ;
      StInit: begin
        test_mode_d = 1'b1;
        lfsr_load_d = 1'b1;
        misr_clr_d  = 1'b1;
        busy_d      = 1'b1;
      end
      StShift, StUnload: begin
        test_mode_d = 1'b1;
        scan_en_d   = 1'b1;
        lfsr_en_d   = 1'b1;
        misr_en_d   = 1'b1;
        busy_d      = 1'b1;
      end
      StCapture: begin
        test_mode_d = 1'b1;
        misr_en_d   = 1'b1;
        busy_d      = 1'b1;
      end
      StCompare: begin
        test_mode_d = 1'b1;
        busy_d      = 1'b1;
      end
      StDone: bist_end_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q       <= StIdle;
      shift_cnt_q   <= '0;
      pattern_cnt_q <= '0;
      pass_fail_q   <= 1'b0;
      test_mode_q   <= 1'b0;
      scan_en_q     <= 1'b0;
      lfsr_load_q   <= 1'b0;
      lfsr_en_q     <= 1'b0;
      misr_clr_q    <= 1'b0;
      misr_en_q     <= 1'b0;
      busy_q        <= 1'b0;
      bist_end_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      shift_cnt_q   <= shift_cnt_d;
      pattern_cnt_q <= pattern_cnt_d;
      pass_fail_q   <= pass_fail_d;
      test_mode_q   <= test_mode_d;
      scan_en_q     <= scan_en_d;
      lfsr_load_q   <= lfsr_load_d;
      lfsr_en_q     <= lfsr_en_d;
      misr_clr_q    <= misr_clr_d;
      misr_en_q     <= misr_en_d;
      busy_q        <= busy_d;
      bist_end_q    <= bist_end_d;
    end
  end

  assign TEST_MODE   = test_mode_q;
  assign SCAN_EN     = scan_en_q;
  assign LFSR_LOAD   = lfsr_load_q;
  assign LFSR_EN     = lfsr_en_q;
  assign MISR_CLR    = misr_clr_q;
  assign MISR_EN     = misr_en_q;
  assign BUSY        = busy_q;
  assign BIST_END    = bist_end_q;
  assign PASS_FAIL   = pass_fail_q;
  assign PATTERN_CNT = pattern_cnt_q;

endmodule

// File: tb/tb_bist_scan_sequencer.sv
// Bench for bist_scan_sequencer: per-cycle vector table on a CHAIN_LEN=1/NUM_PATTERNS=1
// instance, plus full-length sessions, abort and async reset on the default instance.
module tb_bist_scan_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Default instance (a)
  logic       start_a = 1'b0, abort_a = 1'b0;
  logic [7:0] sig_a = 8'h00;
  logic       tm_a, se_a, ld_a, len_a, clr_a, men_a, busy_a, end_a, pf_a;
  logic [7:0] pcnt_a;

  // Minimal instance (b)
  logic       start_b = 1'b0, abort_b = 1'b0;
  logic [7:0] sig_b = 8'h00;
  logic       tm_b, se_b, ld_b, len_b, clr_b, men_b, busy_b, end_b, pf_b;
  logic [7:0] pcnt_b;
  logic [8:0] outs_b;
  assign outs_b = {tm_b, se_b, ld_b, len_b, clr_b, men_b, busy_b, end_b, pf_b};

  bist_scan_sequencer dut_a (
    .CLK(clk), .RST(rst), .START(start_a), .ABORT(abort_a), .SIG(sig_a),
    .TEST_MODE(tm_a), .SCAN_EN(se_a), .LFSR_LOAD(ld_a), .LFSR_EN(len_a),
    .MISR_CLR(clr_a), .MISR_EN(men_a), .BUSY(busy_a), .BIST_END(end_a),
    .PASS_FAIL(pf_a), .PATTERN_CNT(pcnt_a)
  );

  bist_scan_sequencer #(.CHAIN_LEN(1), .NUM_PATTERNS(1)) dut_b (
    .CLK(clk), .RST(rst), .START(start_b), .ABORT(abort_b), .SIG(sig_b),
    .TEST_MODE(tm_b), .SCAN_EN(se_b), .LFSR_LOAD(ld_b), .LFSR_EN(len_b),
    .MISR_CLR(clr_b), .MISR_EN(men_b), .BUSY(busy_b), .BIST_END(end_b),
    .PASS_FAIL(pf_b), .PATTERN_CNT(pcnt_b)
  );

  int n_vec  = 0;
  int n_fail = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_i(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_b(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // {TEST_MODE, SCAN_EN, LFSR_LOAD, LFSR_EN, MISR_CLR, MISR_EN, BUSY, BIST_END, PASS_FAIL}
  localparam logic [8:0] O_IDLE   = 9'b000000000;
  localparam logic [8:0] O_IDLE_P = 9'b000000001;
  localparam logic [8:0] O_INIT   = 9'b101010100;
  localparam logic [8:0] O_SHIFT  = 9'b110101100;
  localparam logic [8:0] O_CAP    = 9'b100001100;
  localparam logic [8:0] O_CMP    = 9'b100000100;
  localparam logic [8:0] O_DONE_P = 9'b000000011;
  localparam logic [8:0] O_DONE_F = 9'b000000010;

  typedef struct {
    logic       start;
    logic       abort;
    logic [7:0] sig;
    logic [8:0] outs;
    logic [7:0] pcnt;
  } vec_t;

  vec_t vecs[25];

  // Full-length session on instance a with phase-timing checks.
  task automatic run_session(input logic [7:0] sig_val, input logic exp_pf, input string tag);
    int edges = 0, runs = 0, bad = 0, run_len = 0, caps = 0, loads = 0, clrs = 0;
    logic prev_se = 1'b0;
    sig_a   = sig_val;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    check_b({tag, "_init_busy"}, busy_a, 1'b1);
    loads = int'(ld_a);
    clrs  = int'(clr_a);
    while (!end_a && edges < 400) begin
      step();
      edges++;
      loads += int'(ld_a);
      clrs  += int'(clr_a);
      if (se_a) begin
        run_len++;
      end else if (prev_se) begin
        runs++;
        if (run_len != 8) bad++;
        if (runs <= 16 && !men_a) bad++;
        if (runs == 17 && men_a) bad++;
        run_len = 0;
      end
      if (busy_a && men_a && !se_a) caps++;
      prev_se = se_a;
    end
    check_i({tag, "_latency"}, edges, 154);
    check_b({tag, "_bist_end"}, end_a, 1'b1);
    check_b({tag, "_pass_fail"}, pf_a, exp_pf);
    check_b({tag, "_busy_done"}, busy_a, 1'b0);
    check_i({tag, "_pattern_cnt"}, int'(pcnt_a), 16);
    check_i({tag, "_scan_runs"}, runs, 17);
    check_i({tag, "_bad_runs"}, bad, 0);
    check_i({tag, "_captures"}, caps, 16);
    check_i({tag, "_lfsr_load_pulses"}, loads, 1);
    check_i({tag, "_misr_clr_pulses"}, clrs, 1);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 8'h00, O_INIT,   8'd0};
    vecs[1]  = '{1'b1, 1'b0, 8'h00, O_SHIFT,  8'd0};
    vecs[2]  = '{1'b0, 1'b0, 8'h00, O_CAP,    8'd0};
    vecs[3]  = '{1'b0, 1'b0, 8'h00, O_SHIFT,  8'd1};
    vecs[4]  = '{1'b0, 1'b0, 8'hA5, O_CMP,    8'd1};
    vecs[5]  = '{1'b1, 1'b0, 8'hA5, O_DONE_P, 8'd1};
    vecs[6]  = '{1'b1, 1'b1, 8'h00, O_DONE_P, 8'd1};
    vecs[7]  = '{1'b0, 1'b0, 8'h00, O_IDLE_P, 8'd0};
    vecs[8]  = '{1'b0, 1'b1, 8'h00, O_IDLE_P, 8'd0};
    vecs[9]  = '{1'b1, 1'b0, 8'h00, O_INIT,   8'd0};
    vecs[10] = '{1'b0, 1'b0, 8'hA4, O_SHIFT,  8'd0};
    vecs[11] = '{1'b0, 1'b1, 8'hA4, O_IDLE,   8'd0};
    vecs[12] = '{1'b1, 1'b0, 8'hA4, O_INIT,   8'd0};
    vecs[13] = '{1'b0, 1'b0, 8'hA4, O_SHIFT,  8'd0};
    vecs[14] = '{1'b0, 1'b0, 8'hA4, O_CAP,    8'd0};
    vecs[15] = '{1'b0, 1'b0, 8'hA4, O_SHIFT,  8'd1};
    vecs[16] = '{1'b0, 1'b0, 8'hA4, O_CMP,    8'd1};
    vecs[17] = '{1'b0, 1'b0, 8'hA4, O_DONE_F, 8'd1};
    vecs[18] = '{1'b0, 1'b0, 8'hA4, O_IDLE,   8'd0};
    vecs[19] = '{1'b1, 1'b0, 8'hA5, O_INIT,   8'd0};
    vecs[20] = '{1'b0, 1'b0, 8'hA5, O_SHIFT,  8'd0};
    vecs[21] = '{1'b0, 1'b0, 8'hA5, O_CAP,    8'd0};
    vecs[22] = '{1'b0, 1'b0, 8'hA5, O_SHIFT,  8'd1};
    vecs[23] = '{1'b0, 1'b0, 8'hA5, O_CMP,    8'd1};
    vecs[24] = '{1'b0, 1'b1, 8'hA5, O_IDLE,   8'd0};

    rst = 1'b1;
    step();
    check_i("reset_outs_a", int'({tm_a, se_a, ld_a, len_a, clr_a, men_a, busy_a, end_a, pf_a}), 0);
    check_i("reset_pcnt_a", int'(pcnt_a), 0);
    check_i("reset_outs_b", int'(outs_b), 0);
    rst = 1'b0;
    step();

    // Minimal-parameter instance, one edge per vector.
    for (int i = 0; i < 25; i++) begin
      start_b = vecs[i].start;
      abort_b = vecs[i].abort;
      sig_b   = vecs[i].sig;
      step();
      check_i($sformatf("vec%0d_outs", i), int'(outs_b), int'(vecs[i].outs));
      check_i($sformatf("vec%0d_pcnt", i), int'(pcnt_b), int'(vecs[i].pcnt));
    end
    start_b = 1'b0;
    abort_b = 1'b0;

    // Pass run, then START held through DONE and released.
    run_session(8'hA5, 1'b1, "pass");
    start_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_b($sformatf("hold_done_end%0d", i), end_a, 1'b1);
      check_b($sformatf("hold_done_busy%0d", i), busy_a, 1'b0);
      check_b($sformatf("hold_done_load%0d", i), ld_a, 1'b0);
    end
    start_a = 1'b0;
    step();
    check_b("release_end", end_a, 1'b0);
    check_b("release_pf_kept", pf_a, 1'b1);
    check_i("release_pcnt", int'(pcnt_a), 0);

    // Abort at cycle 50, then restart from INIT.
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    for (int i = 0; i < 49; i++) step();
    check_b("pre_abort_busy", busy_a, 1'b1);
    abort_a = 1'b1;
    step();
    abort_a = 1'b0;
    check_b("abort_busy", busy_a, 1'b0);
    check_b("abort_pf", pf_a, 1'b0);
    check_b("abort_tm", tm_a, 1'b0);
    check_i("abort_pcnt", int'(pcnt_a), 0);
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    check_b("restart_load", ld_a, 1'b1);
    check_i("restart_pcnt", int'(pcnt_a), 0);
    abort_a = 1'b1;
    step();
    abort_a = 1'b0;
    check_b("abort2_busy", busy_a, 1'b0);

    // Fail run.
    run_session(8'hA4, 1'b0, "fail");
    step();

    // Async reset mid-SHIFT of the fourth pattern.
    sig_a   = 8'hA5;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    for (int i = 0; i < 30; i++) step();
    check_b("pre_rst_scan_en", se_a, 1'b1);
    check_i("pre_rst_pcnt", int'(pcnt_a), 3);
    #2 rst = 1'b1;
    #1;
    check_i("rst_outs", int'({tm_a, se_a, ld_a, len_a, clr_a, men_a, busy_a, end_a, pf_a}), 0);
    check_i("rst_pcnt", int'(pcnt_a), 0);
    step();
    rst = 1'b0;
    step();
    check_b("post_rst_idle_busy", busy_a, 1'b0);
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    check_b("post_rst_init_load", ld_a, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
